// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage RV32I core: PC mux, PC enable and
// per-stage enable/flush. Optional performance counters under `HAZARD_PERF_CNT_EN.

package pcmux;
    typedef enum logic {
        pc_plus4 = 1'b0,
        alu_out  = 1'b1
    } pcmux_sel_t;
endpackage

// state | meaning
// RUN   | normal fetch/issue; stalls for load-use and I-side wait
// DRAIN | redirect issued while a wrong-path fetch was in flight; discard its response
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_resp,
    input  logic                  dmem_req,
    input  logic                  dmem_resp,
    input  logic                  br_en,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  ifid_use_rs1,
    input  logic                  ifid_use_rs2,
    output pcmux::pcmux_sel_t     pcmux_sel,
    output logic                  pc_en,
    output logic                  IFID_en,
    output logic                  IDEX_en,
    output logic                  EXMEM_en,
    output logic                  MEMWB_en,
    output logic                  IFID_flush,
    output logic                  IDEX_flush,
    output logic [CNT_W-1:0]      perf_mem_stall,
    output logic [CNT_W-1:0]      perf_load_use,
    output logic [CNT_W-1:0]      perf_redirect,
    output logic [CNT_W-1:0]      perf_imem_wait
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic mem_stall;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    assign mem_stall = dmem_req & ~dmem_resp;
    assign rs1_hit   = ifid_use_rs1 & (idex_rd == ifid_rs1);
    assign rs2_hit   = ifid_use_rs2 & (idex_rd == ifid_rs2);
    assign load_use  = idex_mem_read & (idex_rd != '0) & (rs1_hit | rs2_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rst) begin
            state_d = ST_RUN;
        end else if (mem_stall) begin
            state_d = state_q;
        end else if (br_en) begin
            // A fetch still outstanding at redirect time is wrong-path and must be drained.
            state_d = imem_resp ? ST_RUN : ST_DRAIN;
        end else if ((state_q == ST_DRAIN) && imem_resp) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        pcmux_sel  = pcmux::pc_plus4;
        pc_en      = 1'b1;
        IFID_en    = 1'b1;
        IDEX_en    = 1'b1;
        EXMEM_en   = 1'b1;
        MEMWB_en   = 1'b1;
        IFID_flush = 1'b0;
        IDEX_flush = 1'b0;
        if (rst || mem_stall) begin
            pc_en    = 1'b0;
            IFID_en  = 1'b0;
            IDEX_en  = 1'b0;
            EXMEM_en = 1'b0;
            MEMWB_en = 1'b0;
        end else if (br_en) begin
            pcmux_sel  = pcmux::alu_out;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end else if (state_q == ST_DRAIN) begin
            // PC already holds the branch target; only the stale response is dropped.
            pc_en      = 1'b0;
            IFID_en    = 1'b0;
            IDEX_flush = 1'b1;
            IFID_flush = imem_resp;
        end else if (load_use || !imem_resp) begin
            pc_en      = 1'b0;
            IFID_en    = 1'b0;
            IDEX_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_ms_q, cnt_ms_d;
    logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d;
    logic [CNT_W-1:0] cnt_rd_q, cnt_rd_d;
    logic [CNT_W-1:0] cnt_iw_q, cnt_iw_d;
    logic             inc_ms;
    logic             inc_lu;
    logic             inc_rd;
    logic             inc_iw;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + 1'b1 : v;
    endfunction

    assign inc_ms = mem_stall;
    assign inc_lu = (state_q == ST_RUN) & load_use & ~mem_stall & ~br_en;
    assign inc_rd = br_en & ~mem_stall;
    // Every DRAIN cycle is a PC hold waiting on the I-side, including the discard cycle.
    assign inc_iw = ~mem_stall & ~br_en &
                    ((state_q == ST_DRAIN) | (~load_use & ~imem_resp));

    assign cnt_ms_d = sat_inc(cnt_ms_q, inc_ms);
    assign cnt_lu_d = sat_inc(cnt_lu_q, inc_lu);
    assign cnt_rd_d = sat_inc(cnt_rd_q, inc_rd);
    assign cnt_iw_d = sat_inc(cnt_iw_q, inc_iw);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_ms_q <= '0;
            cnt_lu_q <= '0;
            cnt_rd_q <= '0;
            cnt_iw_q <= '0;
        end else begin
            cnt_ms_q <= cnt_ms_d;
            cnt_lu_q <= cnt_lu_d;
            cnt_rd_q <= cnt_rd_d;
            cnt_iw_q <= cnt_iw_d;
        end
    end

    assign perf_mem_stall = cnt_ms_q;
    assign perf_load_use  = cnt_lu_q;
    assign perf_redirect  = cnt_rd_q;
    assign perf_imem_wait = cnt_iw_q;
`else
    assign perf_mem_stall = '0;
    assign perf_load_use  = '0;
    assign perf_redirect  = '0;
    assign perf_imem_wait = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares.
module tb_hazard_ctrl;

    localparam int CW = 4;

    localparam logic [7:0] O_OFF = 8'h00;
    localparam logic [7:0] O_DEF = 8'h7C;
    localparam logic [7:0] O_BR  = 8'hFF;
    localparam logic [7:0] O_BUB = 8'h1D;
    localparam logic [7:0] O_DRN = 8'h1F;

    logic clk;
    logic rst;
    logic imem_resp;
    logic dmem_req;
    logic dmem_resp;
    logic br_en;
    logic idex_mem_read;
    logic [4:0] idex_rd;
    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic ifid_use_rs1;
    logic ifid_use_rs2;
    pcmux::pcmux_sel_t pcmux_sel;
    logic pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en, IFID_flush, IDEX_flush;
    logic [CW-1:0] perf_mem_stall, perf_load_use, perf_redirect, perf_imem_wait;

    hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .dmem_resp(dmem_resp), .br_en(br_en), .idex_mem_read(idex_mem_read),
        .idex_rd(idex_rd), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .pcmux_sel(pcmux_sel), .pc_en(pc_en), .IFID_en(IFID_en), .IDEX_en(IDEX_en),
        .EXMEM_en(EXMEM_en), .MEMWB_en(MEMWB_en), .IFID_flush(IFID_flush),
        .IDEX_flush(IDEX_flush), .perf_mem_stall(perf_mem_stall),
        .perf_load_use(perf_load_use), .perf_redirect(perf_redirect),
        .perf_imem_wait(perf_imem_wait)
    );

    typedef struct packed {
        logic       rst;
        logic       imem_resp;
        logic       dmem_req;
        logic       dmem_resp;
        logic       br_en;
        logic       idex_mem_read;
        logic [4:0] idex_rd;
        logic [4:0] ifid_rs1;
        logic [4:0] ifid_rs2;
        logic       use1;
        logic       use2;
    } stim_t;

    typedef struct {
        string          nm;
        logic [7:0]     o;
        bit             chk;
        logic [4*CW-1:0] c;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_e;
    stim_t s;
    int    errors = 0;
    int    checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] ce(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return CW'(v);
`else
        return CW'(v * 0);
`endif
    endfunction

    task automatic apply();
        rst           = s.rst;
        imem_resp     = s.imem_resp;
        dmem_req      = s.dmem_req;
        dmem_resp     = s.dmem_resp;
        br_en         = s.br_en;
        idex_mem_read = s.idex_mem_read;
        idex_rd       = s.idex_rd;
        ifid_rs1      = s.ifid_rs1;
        ifid_rs2      = s.ifid_rs2;
        ifid_use_rs1  = s.use1;
        ifid_use_rs2  = s.use2;
    endtask

    task automatic cyc(input string nm, input logic [7:0] o, input bit chk,
                       input int ms, input int lu, input int rd, input int iw);
        exp_t e;
        @(posedge clk);
        #1;
        apply();
        e.nm  = nm;
        e.o   = o;
        e.chk = chk;
        e.c   = {ce(ms), ce(lu), ce(rd), ce(iw)};
        sb.push_back(e);
    endtask

    task automatic idle();
        s = '0;
        s.imem_resp = 1'b1;
    endtask

    initial begin
        logic [7:0]      act;
        logic [4*CW-1:0] cact;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                act = {pcmux_sel == pcmux::alu_out, pc_en, IFID_en, IDEX_en,
                       EXMEM_en, MEMWB_en, IFID_flush, IDEX_flush};
                checks++;
                if (act !== mon_e.o) begin
                    errors++;
                    $display("FAIL %s: outputs got %b want %b", mon_e.nm, act, mon_e.o);
                end
                if (mon_e.chk) begin
                    cact = {perf_mem_stall, perf_load_use, perf_redirect, perf_imem_wait};
                    checks++;
                    if (cact !== mon_e.c) begin
                        errors++;
                        $display("FAIL %s_cnt: ms/lu/rd/iw got %h want %h", mon_e.nm, cact, mon_e.c);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        s = '0;
        s.rst = 1'b1;
        s.imem_resp = 1'b1;
        s.br_en = 1'b1;
        apply();

        // reset with redirect and ready fetch presented
        cyc("rst0", O_OFF, 1, 0, 0, 0, 0);
        cyc("rst1", O_OFF, 1, 0, 0, 0, 0);
        idle(); cyc("run_after_rst", O_DEF, 1, 0, 0, 0, 0);

        // load-use and I-side wait in RUN
        s.idex_mem_read = 1; s.idex_rd = 5; s.ifid_rs2 = 5; s.use2 = 1;
        cyc("lu_rs2", O_BUB, 0, 0, 0, 0, 0);
        idle(); cyc("lu_clear", O_DEF, 1, 0, 1, 0, 0);
        s.idex_mem_read = 1; s.idex_rd = 0; s.ifid_rs2 = 0; s.use2 = 1;
        cyc("lu_x0", O_DEF, 0, 0, 0, 0, 0);
        idle(); s.idex_mem_read = 1; s.idex_rd = 7; s.ifid_rs1 = 7; s.use1 = 1;
        cyc("lu_rs1", O_BUB, 0, 0, 0, 0, 0);
        s.use1 = 0;
        cyc("lu_unused_src", O_DEF, 0, 0, 0, 0, 0);
        idle(); s.idex_rd = 7; s.ifid_rs1 = 7; s.use1 = 1;
        cyc("no_load", O_DEF, 0, 0, 0, 0, 0);
        idle(); s.dmem_req = 1; s.dmem_resp = 1;
        cyc("mem_hit", O_DEF, 0, 0, 0, 0, 0);
        idle(); s.imem_resp = 0;
        cyc("imem_wait", O_BUB, 0, 0, 0, 0, 0);
        s.idex_mem_read = 1; s.idex_rd = 3; s.ifid_rs1 = 3; s.use1 = 1;
        cyc("lu_imem_wait", O_BUB, 0, 0, 0, 0, 0);
        idle(); cyc("lu_cnt", O_DEF, 1, 0, 3, 0, 1);

        // redirect with ready fetch
        idle(); s.rst = 1; cyc("rst_a", O_OFF, 0, 0, 0, 0, 0);
        idle(); s.br_en = 1; cyc("br_ready", O_BR, 1, 0, 0, 0, 0);
        idle(); cyc("br_ready_run", O_DEF, 1, 0, 0, 1, 0);

        // redirect with busy fetch
        idle(); s.rst = 1; cyc("rst_b", O_OFF, 0, 0, 0, 0, 0);
        idle(); s.imem_resp = 0; s.br_en = 1; cyc("br_busy", O_BR, 1, 0, 0, 0, 0);
        s.br_en = 0;
        for (int i = 0; i < 3; i++) cyc("drain_wait", O_BUB, 0, 0, 0, 0, 0);
        s.imem_resp = 1; cyc("drain_discard", O_DRN, 0, 0, 0, 0, 0);
        idle(); cyc("drain_exit_run", O_DEF, 1, 0, 0, 1, 4);

        // new redirect while draining
        idle(); s.imem_resp = 0; s.br_en = 1; cyc("br_busy2", O_BR, 0, 0, 0, 0, 0);
        s.br_en = 0; cyc("drain_wait2", O_BUB, 0, 0, 0, 0, 0);
        s.br_en = 1; s.imem_resp = 1; cyc("br_in_drain", O_BR, 0, 0, 0, 0, 0);
        idle(); cyc("br_in_drain_run", O_DEF, 1, 0, 0, 3, 5);

        // reset while draining
        idle(); s.imem_resp = 0; s.br_en = 1; cyc("br_busy3", O_BR, 0, 0, 0, 0, 0);
        s.br_en = 0; cyc("drain_wait3", O_BUB, 0, 0, 0, 0, 0);
        s.rst = 1; cyc("rst_in_drain", O_OFF, 0, 0, 0, 0, 0);
        idle(); cyc("rst_drain_run", O_DEF, 1, 0, 0, 0, 0);

        // memory stall masks branch and load-use; branch wins on release
        idle(); s.dmem_req = 1; s.br_en = 1;
        s.idex_mem_read = 1; s.idex_rd = 5; s.ifid_rs2 = 5; s.use2 = 1;
        for (int i = 0; i < 5; i++) cyc("mstall", O_OFF, 0, 0, 0, 0, 0);
        s.dmem_resp = 1; cyc("mstall_release_br", O_BR, 0, 0, 0, 0, 0);
        idle(); cyc("mstall_cnt", O_DEF, 1, 5, 0, 1, 0);

        // memory stall holds DRAIN and does not consume the response
        idle(); s.imem_resp = 0; s.br_en = 1; cyc("br_busy4", O_BR, 0, 0, 0, 0, 0);
        idle(); s.dmem_req = 1; cyc("mstall_in_drain", O_OFF, 0, 0, 0, 0, 0);
        idle(); cyc("drain_after_mstall", O_DRN, 0, 0, 0, 0, 0);
        idle(); cyc("drain_mstall_cnt", O_DEF, 1, 6, 0, 2, 1);

        // counter saturation at 4 bits
        idle(); s.rst = 1; cyc("rst_c", O_OFF, 0, 0, 0, 0, 0);
        idle(); s.dmem_req = 1;
        for (int i = 0; i < 20; i++) cyc("sat", O_OFF, 0, 0, 0, 0, 0);
        idle(); cyc("sat_cnt", O_DEF, 1, 15, 0, 0, 0);

        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_queue: pending %0d want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32I core. It generates the PC-mux select, PC enable, and per-stage enable/flush for IF/ID, ID/EX, EX/MEM and MEM/WB from four event classes: memory-response stalls, load-use hazards and EX-stage branch redirects, plus squashing of a wrong-path instruction fetch that cannot be cancelled. It sits beside the datapath and replaces the combinational branch-only PC select, adding a redirect-drain state machine and optional performance counters.

## Interface
Parameters:
- REG_ADDR_W, 5: width of register specifiers.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_resp  in  1  I-side response. Once asserted it stays asserted, with stable data, until consumed (see Operation).
- dmem_req  in  1  MEM stage holds a load or store.
- dmem_resp  in  1  D-side response for the MEM-stage access.
- br_en  in  1  EX-stage branch/jump taken (target on alu_out).
- idex_mem_read  in  1  ID/EX instruction is a load.
- idex_rd  in  REG_ADDR_W  ID/EX destination register.
- ifid_rs1, ifid_rs2  in  REG_ADDR_W  ID-stage sources.
- ifid_use_rs1, ifid_use_rs2  in  1  ID instruction reads rs1/rs2.
- pcmux_sel  out  pcmux_sel_t  pcmux::pc_plus4 or pcmux::alu_out.
- pc_en  out  1  PC register load.
- IFID_en, IDEX_en, EXMEM_en, MEMWB_en  out  1  stage register load.
- IFID_flush, IDEX_flush  out  1  load a bubble (NOP, valid=0); flush has priority over en.
- perf_mem_stall, perf_load_use, perf_redirect, perf_imem_wait  out  CNT_W  event counters.

## Operation
Terms:
- mem_stall = dmem_req & ~dmem_resp.
- load_use = idex_mem_read & (idex_rd != 0) & ((ifid_use_rs1 & idex_rd == ifid_rs1) | (ifid_use_rs2 & idex_rd == ifid_rs2)).

FSM states: RUN, DRAIN. Defaults: all en=1, flush=0, pc_en=1, pcmux_sel=pc_plus4.

Priority, highest first:
- **rst:** all en=0, pc_en=0, flush=0, pcmux_sel=pc_plus4. Next state RUN.
- **mem_stall:** all en=0, pc_en=0, flush=0. State held. imem_resp is not consumed.
- **br_en (either state):** pcmux_sel=alu_out, pc_en=1, IFID_flush=1, IDEX_flush=1.
  - If imem_resp=1, that response is consumed and the next state is RUN.
  - Otherwise the next state is DRAIN, because the in-flight fetch is wrong-path.
- **DRAIN:** pc_en=0, IFID_en=0, IDEX_flush=1, EXMEM_en=MEMWB_en=1.
  - On imem_resp: IFID_flush=1, the response is discarded (consumed), next state RUN.
  - The PC already holds the target, so the next fetch is the correct path.
- **RUN & load_use:** pc_en=0, IFID_en=0, IDEX_flush=1, EXMEM_en=MEMWB_en=1. This is exactly one bubble per hazard instance.
- **RUN & ~imem_resp:** pc_en=0, IFID_en=0, IDEX_flush=1, back stages advance.
- **RUN otherwise:** defaults. imem_resp is consumed.

Consumption rule: a response is consumed in a cycle with pc_en=1, or on the DRAIN exit cycle.

## Timing
- All outputs are combinational from inputs and state. State and counters are registered.
- Redirect penalty is 2 cycles when imem_resp is coincident with br_en. Otherwise it is 2 plus the imem wait cycles plus 1 discard cycle.
- Load-use penalty is 1 cycle; the forwarding path covers the rest.
- br_en during mem_stall has no effect until the stall clears; EX is frozen, so br_en persists.
- rst asserted in DRAIN returns to RUN on the next edge. The discarded fetch is the memory side's responsibility on reset.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Four CNT_W counters, each cleared by rst and saturating at all-ones.
  - perf_mem_stall +1 per mem_stall cycle.
  - perf_load_use +1 per load_use stall cycle (RUN, no mem_stall, no br_en).
  - perf_redirect +1 per br_en cycle without mem_stall.
  - perf_imem_wait +1 per cycle with pc_en=0 due to ~imem_resp, in RUN or DRAIN.
- Undefined: counter logic is absent and perf_* ports are tied to 0.

## Test plan
- **Reset:** rst=1 for 2 cycles with imem_resp=1 and br_en=1 -> all en/pc_en=0, flushes=0, pcmux_sel=pc_plus4, state RUN after release. With the macro, counters read 0.
- **Load-use:** idex_mem_read=1, idex_rd=5, ifid_rs2=5, ifid_use_rs2=1, imem_resp=1 -> one cycle of pc_en=0, IFID_en=0, IDEX_flush=1. With idex_rd=0 -> no stall.
- **Redirect with ready fetch:** br_en=1, imem_resp=1 -> pcmux_sel=alu_out, pc_en=1, IFID_flush=IDEX_flush=1; next cycle in RUN.
- **Redirect with busy fetch:** br_en=1, imem_resp=0, then imem_resp=0 for 3 more cycles, then 1 -> DRAIN for 4 cycles with pc_en=0. On the resp cycle IFID_flush=1, pc_en=0. Next cycle RUN. perf_redirect=1, perf_imem_wait=4.
- **Memory stall overlap:** dmem_req=1, dmem_resp=0 for 5 cycles while br_en=1 and load_use=1 -> all en=0, pcmux_sel=pc_plus4. On dmem_resp=1 the redirect fires (branch beats load_use). perf_mem_stall=5.
- **Counter saturation:** with CNT_W=4, hold mem_stall for 20 cycles -> perf_mem_stall holds at 15.
